// File: rtl/sys_ctrl.sv
// Command sequencer: parses framed RX bytes into register-file and ALU
// operations and pushes response bytes into the TX FIFO.
module sys_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUN_WIDTH  = 4,
  parameter logic [DATA_WIDTH-1:0] CMD_WR      = 8'hAA,
  parameter logic [DATA_WIDTH-1:0] CMD_RD      = 8'hBB,
  parameter logic [DATA_WIDTH-1:0] CMD_ALU_OP  = 8'hCC,
  parameter logic [DATA_WIDTH-1:0] CMD_ALU_NOP = 8'hDD
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
  input  logic                    RX_D_VLD,
  input  logic [DATA_WIDTH-1:0]   RdData,
  input  logic                    RdData_Valid,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    OUT_Valid,
  input  logic                    FIFO_FULL,
  output logic                    WrEn,
  output logic                    RdEn,
  output logic [ADDR_WIDTH-1:0]   Address,
  output logic [DATA_WIDTH-1:0]   WrData,
  output logic                    ALU_EN,
  output logic [FUN_WIDTH-1:0]    ALU_FUN,
  output logic                    CLK_EN,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_D_VLD,
  output logic [3:0]              dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_WR_ADDR  = 4'd1,
    S_WR_DATA  = 4'd2,
    S_RD_ADDR  = 4'd3,
    S_RD_WAIT  = 4'd4,
    S_RD_SEND  = 4'd5,
    S_ALU_A    = 4'd6,
    S_ALU_B    = 4'd7,
    S_ALU_FUN  = 4'd8,
    S_ALU_WAIT = 4'd9,
    S_SEND_LO  = 4'd10,
    S_SEND_HI  = 4'd11
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   rd_byte_q, rd_byte_d;
  logic [2*DATA_WIDTH-1:0] res_q, res_d;

  logic                    wr_en_d, rd_en_d, alu_en_d, clk_en_d, tx_vld_d;
  logic [ADDR_WIDTH-1:0]   address_d;
  logic [DATA_WIDTH-1:0]   wr_data_d, tx_data_d;
  logic [FUN_WIDTH-1:0]    alu_fun_d;

  assign dbg_state = state_q;

  // Handshakes: RX_D_VLD, RdData_Valid and OUT_Valid are one-cycle strobes with
  // no ready; they are consumed only in the states that expect them. TX push:
  // TX_D_VLD pulses the cycle after FIFO_FULL was seen low, otherwise the byte
  // stays held in its send state until the FIFO drains.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rd_byte_d = rd_byte_q;
    res_d     = res_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    alu_en_d  = 1'b0;
    tx_vld_d  = 1'b0;
    clk_en_d  = CLK_EN;
    address_d = Address;
    wr_data_d = WrData;
    alu_fun_d = ALU_FUN;
    tx_data_d = TX_P_DATA;

    case (state_q)
      S_IDLE: begin
        if (RX_D_VLD) begin
          case (RX_P_DATA)
            CMD_WR:      state_d = S_WR_ADDR;
            CMD_RD:      state_d = S_RD_ADDR;
            CMD_ALU_OP:  state_d = S_ALU_A;
            CMD_ALU_NOP: state_d = S_ALU_FUN;
            default:     state_d = S_IDLE;
          endcase
        end
      end

      S_WR_ADDR: begin
        if (RX_D_VLD) begin
          addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
          state_d = S_WR_DATA;
        end
      end

      S_WR_DATA: begin
        if (RX_D_VLD) begin
          wr_en_d   = 1'b1;
          address_d = addr_q;
          wr_data_d = RX_P_DATA;
          state_d   = S_IDLE;
        end
      end

      S_RD_ADDR: begin
        if (RX_D_VLD) begin
          rd_en_d   = 1'b1;
          address_d = RX_P_DATA[ADDR_WIDTH-1:0];
          state_d   = S_RD_WAIT;
        end
      end

      // Push straight from the valid cycle when possible to keep the
      // valid-to-TX latency at one cycle; RD_SEND only covers a full FIFO.
      S_RD_WAIT: begin
        if (RdData_Valid) begin
          rd_byte_d = RdData;
          if (!FIFO_FULL) begin
            tx_vld_d  = 1'b1;
            tx_data_d = RdData;
            state_d   = S_IDLE;
          end else begin
            state_d   = S_RD_SEND;
          end
        end
      end

      S_RD_SEND: begin
        if (!FIFO_FULL) begin
          tx_vld_d  = 1'b1;
          tx_data_d = rd_byte_q;
          state_d   = S_IDLE;
        end
      end

      S_ALU_A: begin
        if (RX_D_VLD) begin
          wr_en_d   = 1'b1;
          address_d = ADDR_WIDTH'(0);
          wr_data_d = RX_P_DATA;
          state_d   = S_ALU_B;
        end
      end

      S_ALU_B: begin
        if (RX_D_VLD) begin
          wr_en_d   = 1'b1;
          address_d = ADDR_WIDTH'(1);
          wr_data_d = RX_P_DATA;
          state_d   = S_ALU_FUN;
        end
      end

      S_ALU_FUN: begin
        if (RX_D_VLD) begin
          alu_en_d  = 1'b1;
          clk_en_d  = 1'b1;
          alu_fun_d = RX_P_DATA[FUN_WIDTH-1:0];
          state_d   = S_ALU_WAIT;
        end
      end

      // The ALU clock stays enabled through the OUT_Valid cycle itself.
      S_ALU_WAIT: begin
        clk_en_d = 1'b1;
        if (OUT_Valid) begin
          res_d    = ALU_OUT;
          clk_en_d = 1'b0;
          if (!FIFO_FULL) begin
            tx_vld_d  = 1'b1;
            tx_data_d = ALU_OUT[DATA_WIDTH-1:0];
            state_d   = S_SEND_HI;
          end else begin
            state_d   = S_SEND_LO;
          end
        end
      end

      S_SEND_LO: begin
        if (!FIFO_FULL) begin
          tx_vld_d  = 1'b1;
          tx_data_d = res_q[DATA_WIDTH-1:0];
          state_d   = S_SEND_HI;
        end
      end

      S_SEND_HI: begin
        if (!FIFO_FULL) begin
          tx_vld_d  = 1'b1;
          tx_data_d = res_q[2*DATA_WIDTH-1:DATA_WIDTH];
          state_d   = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      rd_byte_q <= '0;
      res_q     <= '0;
      WrEn      <= 1'b0;
      RdEn      <= 1'b0;
      ALU_EN    <= 1'b0;
      CLK_EN    <= 1'b0;
      TX_D_VLD  <= 1'b0;
      Address   <= '0;
      WrData    <= '0;
      ALU_FUN   <= '0;
      TX_P_DATA <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rd_byte_q <= rd_byte_d;
      res_q     <= res_d;
      WrEn      <= wr_en_d;
      RdEn      <= rd_en_d;
      ALU_EN    <= alu_en_d;
      CLK_EN    <= clk_en_d;
      TX_D_VLD  <= tx_vld_d;
      Address   <= address_d;
      WrData    <= wr_data_d;
      ALU_FUN   <= alu_fun_d;
      TX_P_DATA <= tx_data_d;
    end
  end

endmodule
